// File: rtl/ram_arbiter.sv
// Two-requester command arbiter in front of a single-port RAM: clears the RAM after reset,
// then grants requester 0 by priority with a bounded-wait guard for requester 1.
module ram_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              write_enb,
  output logic              read_enb,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              init_done
);

  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sc;
  logic              sweep_end;
  logic [3:0]        wc;
  logic              force1;
  logic              acc;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [1:0]        vld_pipe;
  logic [1:0]        id_pipe;

  assign force1 = (wc >= 4'(MAX_WAIT));
  assign gnt0   = (state == S_ARB) && req0 && !force1;
  assign gnt1   = (state == S_ARB) && req1 && (!req0 || force1);
  assign acc    = gnt0 || gnt1;

  always_comb begin
    acc_we    = we0;
    acc_addr  = addr0;
    acc_wdata = wdata0;
    if (gnt1) begin
      acc_we    = we1;
      acc_addr  = addr1;
      acc_wdata = wdata1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      sc        <= '0;
      sweep_end <= 1'b0;
      wc        <= '0;
      write_enb <= 1'b0;
      read_enb  <= 1'b0;
      address   <= '0;
      data_in   <= '0;
      init_done <= 1'b0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          read_enb <= 1'b0;
          wc       <= '0;
          if (!sweep_end) begin
            write_enb <= 1'b1;
            address   <= sc;
            data_in   <= '0;
            sc        <= sc + 1'b1;
            if (sc == {ADDR_W{1'b1}}) sweep_end <= 1'b1;
          end else begin
            // sweep fully issued: one idle edge to drop the strobe, then open arbitration
            write_enb <= 1'b0;
            sweep_end <= 1'b0;
            init_done <= 1'b1;
            state     <= S_ARB;
          end
        end
        S_ARB: begin
          write_enb <= acc && acc_we;
          read_enb  <= acc && !acc_we;
          if (acc) begin
            address <= acc_addr;
            data_in <= acc_we ? acc_wdata : '0;
          end
          if (req1 && !gnt1) wc <= (wc == 4'hF) ? wc : wc + 1'b1;
          else               wc <= '0;
        end
        default: state <= S_INIT;
      endcase

      // tag pipe: [0] rides with read_enb, [1] with data_out valid
      vld_pipe[0] <= acc && !acc_we;
      id_pipe[0]  <= gnt1;
      vld_pipe[1] <= vld_pipe[0];
      id_pipe[1]  <= id_pipe[0];
      rvalid0     <= vld_pipe[1] && !id_pipe[1];
      rvalid1     <= vld_pipe[1] && id_pipe[1];
      if (vld_pipe[1] && !id_pipe[1]) rdata0 <= data_out;
      if (vld_pipe[1] && id_pipe[1])  rdata1 <= data_out;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, directed vector table, random traffic against a
// transaction-level model (shadow memory + return queue), and reset/sweep checks.
module tb_ram_arbiter;

  localparam int MW = 3;

  logic       clk, reset;
  logic       req0, req1, we0, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       write_enb, read_enb, init_done;
  logic [4:0] address;
  logic [7:0] data_in, data_out;

  ram_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .write_enb(write_enb), .read_enb(read_enb), .address(address),
    .data_in(data_in), .data_out(data_out), .init_done(init_done)
  );

  // 32x8 single-port RAM, preloaded with non-zero junk so the clear sweep is observable
  logic [7:0] mem [32] = '{default: 8'h5A};
  always @(posedge clk) begin
    if (write_enb) mem[address] <= data_in;
    if (read_enb)  data_out <= mem[address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // transaction-level model
  typedef struct {
    int         cyc;
    logic       port;
    logic [7:0] data;
  } ret_t;

  ret_t       rq[$];
  logic [7:0] sm [32];
  int         mwc;
  logic [7:0] mrd0, mrd1;
  logic       exp_we, exp_re;
  logic [4:0] exp_addr;
  logic [7:0] exp_din;

  task automatic model_reset();
    rq.delete();
    for (int i = 0; i < 32; i++) sm[i] = 8'h00;
    mwc = 0; mrd0 = 8'h00; mrd1 = 8'h00;
    exp_we = 1'b0; exp_re = 1'b0; exp_addr = 5'd31; exp_din = 8'h00;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_gnt0"}, 32'(gnt0), 0);
    chk({tag, "_gnt1"}, 32'(gnt1), 0);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 0);
    chk({tag, "_rvalid1"}, 32'(rvalid1), 0);
  endtask

  // Asserts reset at the current time, checks reset values, releases and checks the sweep.
  task automatic do_reset(input logic hold_req0);
    reset = 1'b1;
    req0 = hold_req0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 5'd0; addr1 = 5'd0; wdata0 = 8'h00; wdata1 = 8'h00;
    #2;
    chk_idle_outs("rst");
    chk("rst_rdata0", 32'(rdata0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    chk("rst_write_enb", 32'(write_enb), 0);
    chk("rst_read_enb", 32'(read_enb), 0);
    chk("rst_address", 32'(address), 0);
    chk("rst_data_in", 32'(data_in), 0);
    chk("rst_init_done", 32'(init_done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1; cyc++;
      chk("init_we", 32'(write_enb), 1);
      chk("init_addr", 32'(address), 32'(i));
      chk("init_din", 32'(data_in), 0);
      chk("init_done_lo", 32'(init_done), 0);
      chk_idle_outs("init");
    end
    @(posedge clk); #1; cyc++;
    chk("sweep_end_we", 32'(write_enb), 0);
    chk("sweep_end_re", 32'(read_enb), 0);
    chk("sweep_end_done", 32'(init_done), 1);
    model_reset();
  endtask

  // One ARB cycle: apply inputs, check DUT against model, advance one edge.
  task automatic step(input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1,
                      output logic acc0, output logic acc1, output logic g0d, output logic g1d);
    logic mf, mg0, mg1, e0, e1, w;
    logic [4:0] a;
    logic [7:0] d;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    mf  = (mwc >= MW);
    mg0 = r0 && !mf;
    mg1 = r1 && (!r0 || mf);
    g0d = gnt0; g1d = gnt1;
    chk("gnt0", 32'(gnt0), 32'(mg0));
    chk("gnt1", 32'(gnt1), 32'(mg1));
    e0 = 1'b0; e1 = 1'b0;
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      if (rq[0].port) begin e1 = 1'b1; mrd1 = rq[0].data; end
      else            begin e0 = 1'b1; mrd0 = rq[0].data; end
      void'(rq.pop_front());
    end
    chk("rvalid0", 32'(rvalid0), 32'(e0));
    chk("rvalid1", 32'(rvalid1), 32'(e1));
    chk("rdata0", 32'(rdata0), 32'(mrd0));
    chk("rdata1", 32'(rdata1), 32'(mrd1));
    chk("write_enb", 32'(write_enb), 32'(exp_we));
    chk("read_enb", 32'(read_enb), 32'(exp_re));
    chk("address", 32'(address), 32'(exp_addr));
    chk("data_in", 32'(data_in), 32'(exp_din));
    chk("init_done", 32'(init_done), 1);
    exp_we = 1'b0; exp_re = 1'b0;
    if (mg0 || mg1) begin
      w = mg1 ? w1 : w0; a = mg1 ? a1 : a0; d = mg1 ? d1 : d0;
      exp_we = w; exp_re = !w; exp_addr = a; exp_din = w ? d : 8'h00;
      if (w) sm[a] = d;
      else   rq.push_back('{cyc + 3, mg1, sm[a]});
    end
    if (r1 && !mg1) mwc = (mwc < 15) ? mwc + 1 : 15;
    else            mwc = 0;
    acc0 = mg0; acc1 = mg1;
    @(posedge clk); #1; cyc++;
  endtask

  typedef struct {
    logic       r0, w0; logic [4:0] a0; logic [7:0] d0;
    logic       r1, w1; logic [4:0] a1; logic [7:0] d1;
    logic       eg0, eg1;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                              input logic r1, input logic w1, input logic [4:0] a1,
                              input logic eg0, input logic eg1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = 8'hEE;
    v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  vec_t tbl [22];
  logic p0, p1, c0w, c1w, ac0, ac1, g0d, g1d;
  logic [4:0] c0a, c1a;
  logic [7:0] c0d, c1d;

  initial begin
    tbl[0]  = mk(1, 1, 5, 8'hA5, 0, 0, 0, 1, 0);  // write 5
    tbl[1]  = mk(1, 0, 5, 8'h00, 0, 0, 0, 1, 0);  // read-after-write 5
    tbl[2]  = mk(1, 1, 5, 8'h77, 1, 0, 9, 1, 0);  // write behind in-flight read; r1 blocked
    tbl[3]  = mk(0, 0, 0, 8'h00, 1, 0, 9, 0, 1);  // r1 reads never-written addr 9
    tbl[4]  = mk(1, 1, 1, 8'h11, 0, 0, 0, 1, 0);
    tbl[5]  = mk(1, 1, 2, 8'h22, 0, 0, 0, 1, 0);
    tbl[6]  = mk(1, 1, 3, 8'h33, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 1, 8'h00, 0, 0, 0, 1, 0);  // back-to-back reads 1,2,3
    tbl[8]  = mk(1, 0, 2, 8'h00, 0, 0, 0, 1, 0);
    tbl[9]  = mk(1, 0, 3, 8'h00, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 5, 8'h00, 1, 0, 3, 1, 0);  // both held: 0,0,0,1,0,0,0,1
    tbl[12] = mk(1, 0, 5, 8'h00, 1, 0, 3, 1, 0);
    tbl[13] = mk(1, 0, 5, 8'h00, 1, 0, 3, 1, 0);
    tbl[14] = mk(1, 0, 5, 8'h00, 1, 0, 3, 0, 1);
    tbl[15] = mk(1, 0, 5, 8'h00, 1, 0, 9, 1, 0);
    tbl[16] = mk(1, 0, 5, 8'h00, 1, 0, 9, 1, 0);
    tbl[17] = mk(1, 0, 5, 8'h00, 1, 0, 9, 1, 0);
    tbl[18] = mk(1, 0, 5, 8'h00, 1, 0, 9, 0, 1);
    tbl[19] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0);

    do_reset(1'b1);  // req0 held through INIT must never see a grant

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
           tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, ac0, ac1, g0d, g1d);
      chk($sformatf("tbl%0d_gnt0", i), 32'(g0d), 32'(tbl[i].eg0));
      chk($sformatf("tbl%0d_gnt1", i), 32'(g1d), 32'(tbl[i].eg1));
    end

    // random traffic; each requester holds its command until accepted
    p0 = 1'b0; p1 = 1'b0;
    c0w = 1'b0; c1w = 1'b0; c0a = 5'd0; c1a = 5'd0; c0d = 8'h00; c1d = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; c0w = 1'($urandom_range(0, 1));
        c0a = 5'($urandom_range(0, 7)); c0d = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; c1w = 1'($urandom_range(0, 1));
        c1a = 5'($urandom_range(0, 7)); c1d = 8'($urandom);
      end
      step(p0, c0w, c0a, c0d, p1, c1w, c1a, c1d, ac0, ac1, g0d, g1d);
      if (ac0) p0 = 1'b0;
      if (ac1) p1 = 1'b0;
    end
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0, 0, 0, ac0, ac1, g0d, g1d);
    chk("rand_drained", 32'(rq.size()), 0);

    // reset one cycle after a read accept: read is dropped, sweep restarts at 0
    step(1, 1, 4, 8'h3C, 0, 0, 0, 0, ac0, ac1, g0d, g1d);
    step(1, 0, 4, 8'h00, 0, 0, 0, 0, ac0, ac1, g0d, g1d);
    do_reset(1'b0);
    step(0, 0, 0, 0, 1, 0, 4, 0, ac0, ac1, g0d, g1d);  // addr 4 cleared again
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0, 0, 0, ac0, ac1, g0d, g1d);
    chk("post_reset_rdata1", 32'(rdata1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
